// File: rtl/da_filter_seq.sv
// Control sequencer for the bit-serial distributed-arithmetic FIR datapath.
// Accepts a sample, runs DATA_W bit-cycles of shift/accumulate, then presents the result.
module da_filter_seq #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             load_we,
  output logic             tap_we,
  output logic             shift_en,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             acc_sub,
  output logic [CNT_W-1:0] bit_idx,
  output logic             out_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCalc,
    StCapt,
    StHold
  } state_e;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(DATA_W - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_idx_q, bit_idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    in_ready  = 1'b0;
    load_we   = 1'b0;
    tap_we    = 1'b0;
    shift_en  = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    acc_sub   = 1'b0;
    out_we    = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      StIdle: begin
        in_ready  = 1'b1;
        bit_idx_d = '0;
        if (in_valid) state_d = StLoad;
      end
      StLoad: begin
        load_we   = 1'b1;
        tap_we    = 1'b1;
        acc_clr   = 1'b1;
        bit_idx_d = '0;
        state_d   = abort ? StIdle : StCalc;
      end
      StCalc: begin
        if (abort) begin
          acc_clr   = 1'b1;
          bit_idx_d = '0;
          state_d   = StIdle;
        end else begin
          shift_en = 1'b1;
          acc_en   = 1'b1;
          // The MSB carries negative weight in two's complement.
          acc_sub  = (bit_idx_q == LastIdx);
          if (bit_idx_q == LastIdx) begin
            bit_idx_d = '0;
            state_d   = StCapt;
          end else begin
            bit_idx_d = bit_idx_q + CNT_W'(1);
          end
        end
      end
      StCapt: begin
        if (abort) begin
          acc_clr = 1'b1;
          state_d = StIdle;
        end else begin
          out_we  = 1'b1;
          state_d = StHold;
        end
        bit_idx_d = '0;
      end
      StHold: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? StLoad : StIdle;
      end
      default: begin
        state_d   = StIdle;
        bit_idx_d = '0;
      end
    endcase
  end

  assign bit_idx = bit_idx_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_da_filter_seq.sv
// Bench for da_filter_seq: directed vector table at DATA_W=4 and a randomized run at DATA_W=20
// against a cycles-since-acceptance reference model.
module tb_da_filter_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DATA_W=4 instance
  logic iv4, ir4, ab4, lw4, tw4, se4, ac4, ae4, as4, ow4, ov4, or4, bz4;
  logic [1:0] bi4;
  // DATA_W=20 instance
  logic iv20, ir20, ab20, lw20, tw20, se20, ac20, ae20, as20, ow20, ov20, or20, bz20;
  logic [4:0] bi20;

  da_filter_seq #(.DATA_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .abort(ab4),
    .load_we(lw4), .tap_we(tw4), .shift_en(se4), .acc_clr(ac4), .acc_en(ae4),
    .acc_sub(as4), .bit_idx(bi4), .out_we(ow4), .out_valid(ov4), .out_ready(or4),
    .busy(bz4)
  );

  da_filter_seq u20 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv20), .in_ready(ir20), .abort(ab20),
    .load_we(lw20), .tap_we(tw20), .shift_en(se20), .acc_clr(ac20), .acc_en(ae20),
    .acc_sub(as20), .bit_idx(bi20), .out_we(ow20), .out_valid(ov20), .out_ready(or20),
    .busy(bz20)
  );

  // Flag order: load_we tap_we shift_en acc_clr acc_en acc_sub out_we out_valid busy in_ready
  logic [9:0] f4, f20;
  assign f4  = {lw4, tw4, se4, ac4, ae4, as4, ow4, ov4, bz4, ir4};
  assign f20 = {lw20, tw20, se20, ac20, ae20, as20, ow20, ov20, bz20, ir20};

  localparam logic [9:0] IdleF  = 10'b0000000001;
  localparam logic [9:0] LoadF  = 10'b1101000010;
  localparam logic [9:0] CalcF  = 10'b0010100010;
  localparam logic [9:0] CalcSF = 10'b0010110010;
  localparam logic [9:0] CaptF  = 10'b0000001010;
  localparam logic [9:0] Hold0F = 10'b0000000110;
  localparam logic [9:0] Hold1F = 10'b0000000111;
  localparam logic [9:0] AbrtF  = 10'b0001000010;

  typedef struct {
    logic       iv;
    logic       orr;
    logic       ab;
    logic [9:0] f;
    int         b;
  } vec_t;

  vec_t tv[26];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: expected outputs as a function of cycles since acceptance (0 = idle).
  function automatic logic [9:0] model_flags(input int k, input logic orr);
    int  w = 20;
    logic ld, sh, sub, cap, hold;
    ld   = (k == 1);
    sh   = (k >= 2) && (k <= w + 1);
    sub  = (k == w + 1);
    cap  = (k == w + 2);
    hold = (k == w + 3);
    return {ld, ld, sh, ld, sh, sub, cap, hold, (k != 0), (k == 0) || (hold && orr)};
  endfunction

  initial begin
    int loads, outs, last_load, n, k, sub_cnt, cyc;

    tv[0]  = '{1'b1, 1'b1, 1'b0, IdleF,  0};
    tv[1]  = '{1'b0, 1'b1, 1'b0, LoadF,  0};
    tv[2]  = '{1'b0, 1'b1, 1'b0, CalcF,  0};
    tv[3]  = '{1'b0, 1'b1, 1'b0, CalcF,  1};
    tv[4]  = '{1'b0, 1'b1, 1'b0, CalcF,  2};
    tv[5]  = '{1'b0, 1'b1, 1'b0, CalcSF, 3};
    tv[6]  = '{1'b0, 1'b0, 1'b0, CaptF,  0};
    tv[7]  = '{1'b1, 1'b0, 1'b0, Hold0F, 0};
    tv[8]  = '{1'b1, 1'b0, 1'b0, Hold0F, 0};
    tv[9]  = '{1'b1, 1'b0, 1'b1, Hold0F, 0};
    tv[10] = '{1'b1, 1'b0, 1'b0, Hold0F, 0};
    tv[11] = '{1'b1, 1'b0, 1'b0, Hold0F, 0};
    tv[12] = '{1'b1, 1'b1, 1'b0, Hold1F, 0};
    tv[13] = '{1'b0, 1'b1, 1'b0, LoadF,  0};
    tv[14] = '{1'b0, 1'b1, 1'b0, CalcF,  0};
    tv[15] = '{1'b0, 1'b1, 1'b0, CalcF,  1};
    tv[16] = '{1'b0, 1'b1, 1'b1, AbrtF,  2};
    tv[17] = '{1'b1, 1'b1, 1'b0, IdleF,  0};
    tv[18] = '{1'b0, 1'b1, 1'b0, LoadF,  0};
    tv[19] = '{1'b0, 1'b1, 1'b0, CalcF,  0};
    tv[20] = '{1'b0, 1'b1, 1'b0, CalcF,  1};
    tv[21] = '{1'b0, 1'b1, 1'b0, CalcF,  2};
    tv[22] = '{1'b0, 1'b1, 1'b0, CalcSF, 3};
    tv[23] = '{1'b0, 1'b1, 1'b0, CaptF,  0};
    tv[24] = '{1'b0, 1'b1, 1'b1, Hold1F, 0};
    tv[25] = '{1'b0, 1'b1, 1'b1, IdleF,  0};

    rst_n = 1'b0;
    {iv4, ab4, iv20, ab20} = '0;
    or4 = 1'b1;
    or20 = 1'b1;
    repeat (2) step();
    iv4 = 1'b1;  // must be ignored under reset
    step();
    chk("reset_flags4", 32'(f4), 32'(IdleF));
    chk("reset_bidx4", 32'(bi4), 0);
    chk("reset_flags20", 32'(f20), 32'(IdleF));
    chk("reset_bidx20", 32'(bi20), 0);
    iv4 = 1'b0;
    rst_n = 1'b1;
    step();

    // Directed single sample, backpressure, abort and ignored-abort sequence.
    for (int i = 0; i < 26; i++) begin
      iv4 = tv[i].iv;
      or4 = tv[i].orr;
      ab4 = tv[i].ab;
      #1;
      chk($sformatf("vec%0d_flags", i), 32'(f4), 32'(tv[i].f));
      chk($sformatf("vec%0d_bidx", i), 32'(bi4), 32'(tv[i].b));
      step();
    end
    ab4 = 1'b0;

    // Back-to-back streaming: one sample per DATA_W+3 cycles.
    iv4 = 1'b1;
    or4 = 1'b1;
    loads = 0;
    outs = 0;
    last_load = -1;
    for (int c = 0; c < 70; c++) begin
      if (lw4) begin
        if (last_load >= 0) chk("stream_load_gap", 32'(c - last_load), 7);
        last_load = c;
        loads++;
      end
      if (ow4) outs++;
      step();
    end
    chk("stream_loads", 32'(loads), 10);
    chk("stream_out_we", 32'(outs), 10);
    iv4 = 1'b0;
    repeat (2) step();
    chk("stream_drain_busy", 32'(bz4), 0);

    // Asynchronous reset in the middle of CALC.
    iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    repeat (2) step();
    chk("pre_reset_bidx", 32'(bi4), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_flags", 32'(f4), 32'(IdleF));
    chk("async_rst_bidx", 32'(bi4), 0);
    step();
    chk("rst_no_out_we", 32'(ow4), 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(ir4), 1);
    iv4 = 1'b1;
    @(posedge clk);
    #1;
    iv4 = 1'b0;
    n = 0;
    while (!ov4 && n < 50) begin
      step();
      n++;
    end
    chk("post_rst_latency", 32'(n), 6);
    step();

    // Randomized DATA_W=20 run against the reference model.
    k = 0;
    outs = 0;
    sub_cnt = 0;
    cyc = 0;
    while (outs < 100 && cyc < 20000) begin
      iv20 = ($urandom_range(0, 3) == 0);
      or20 = ($urandom_range(0, 2) != 0);
      #1;
      chk("rand_flags", 32'(f20), 32'(model_flags(k, or20)));
      chk("rand_bidx", 32'(bi20), (k >= 2 && k <= 21) ? 32'(k - 2) : 0);
      if (as20) sub_cnt++;
      if (ow20) begin
        chk("rand_sub_once", 32'(sub_cnt), 1);
        sub_cnt = 0;
        outs++;
      end
      if (k == 0)       k = iv20 ? 1 : 0;
      else if (k <= 22) k = k + 1;
      else if (or20)    k = iv20 ? 1 : 0;
      step();
      cyc++;
    end
    chk("rand_samples", 32'(outs), 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
